arb_muxnv: RTL and testbench

- N-channel registered stream multiplexer: selects one of N valid/ready input channels by round-robin arbitration.
- Forwards the winning channel's data through a one-entry output register with valid/ready handshake.
- Successor to the combinational mux2v..mux8v family: parametrised in width and channel count, pipelined, and back-pressure aware.
- Sits between multiple requesters (e.g. I/D-side memory requests, writeback sources) and a single shared consumer.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_muxnv_rr_arbiter.sv | 59 +++++
 rtl/arb_muxnv.sv | 143 ++++++++++++++
 tb/tb_arb_muxnv.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the arb_muxnv stream multiplexer and its arbiter.
// Contents:
//   clog2_min1(n) - ceil(log2(n)), but never less than 1, so that a
//                   single-channel build still has a 1-bit index field.
package arb_pkg;

    function automatic int clog2_min1(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/arb_muxnv_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search.
// Optional macro: ARB_MUXNV_LOCK_EN adds lock_i/owner_i; while lock_i is
// high only the owner channel may be granted.
// Ports:
//   req_i       [channels-1:0] request vector
//   ptr_i       [SEL_W-1:0]    channel with highest priority this cycle
//   lock_i      (LOCK_EN only) restrict grant to owner_i
//   owner_i     (LOCK_EN only) index of the locked channel
//   grant_oh_o  [channels-1:0] one-hot grant (all zero when no request)
//   grant_idx_o [SEL_W-1:0]    encoded grant index (0 when no grant)
//   grant_any_o                a grant was issued
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int channels = 4,
    localparam int SEL_W    = clog2_min1(channels)
) (
    input  logic [channels-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
`ifdef ARB_MUXNV_LOCK_EN
    input  logic                lock_i,
    input  logic [SEL_W-1:0]    owner_i,
`endif
    output logic [channels-1:0] grant_oh_o,
    output logic [SEL_W-1:0]    grant_idx_o,
    output logic                grant_any_o
);

    logic [channels-1:0] eff_req_s;
    int                  cand_s;
    logic                hit_s;

    // Mask requests to the lock owner when a packet is in flight.
    always_comb begin
`ifdef ARB_MUXNV_LOCK_EN
        eff_req_s = lock_i ? (req_i & ({{(channels-1){1'b0}}, 1'b1} << owner_i)) : req_i;
`else
        eff_req_s = req_i;
`endif
    end

    // Walk ptr, ptr+1, ... modulo channels; the first requester wins.
    always_comb begin
        grant_oh_o  = {channels{1'b0}};
        grant_idx_o = {SEL_W{1'b0}};
        grant_any_o = 1'b0;
        cand_s      = 0;
        hit_s       = 1'b0;
        for (int k = 0; k < channels; k++) begin
            cand_s = int'(ptr_i) + k;
            cand_s = (cand_s >= channels) ? (cand_s - channels) : cand_s;
            hit_s  = !grant_any_o && eff_req_s[cand_s];
            grant_oh_o[cand_s] = hit_s;
            grant_idx_o        = hit_s ? SEL_W'(cand_s) : grant_idx_o;
            grant_any_o        = grant_any_o | hit_s;
        end
    end

endmodule

// File: rtl/arb_muxnv.sv
// arb_muxnv: N-channel round-robin stream multiplexer with a one-entry
// registered output stage (valid/ready on both sides).
// Optional macro: ARB_MUXNV_LOCK_EN adds in_last/out_last and packet lock;
// a beat with in_last=0 keeps the grant on its channel until in_last=1.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   in_valid      [channels-1:0]       per-channel request
//   in_ready      [channels-1:0]       one-hot accept for the granted channel
//   in_data       [channels*width-1:0] channel i at [i*width +: width]
//   in_last       (LOCK_EN only) per-channel end-of-packet marker
//   out_valid     output register holds a beat
//   out_ready     consumer accepts the beat
//   out_data      [width-1:0] registered data
//   out_sel       [SEL_W-1:0] registered source channel index
//   out_last      (LOCK_EN only) registered end-of-packet marker
module arb_muxnv
    import arb_pkg::*;
#(
    parameter  int width    = 32,
    parameter  int channels = 4,
    localparam int SEL_W    = clog2_min1(channels)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [channels-1:0]       in_valid,
    output logic [channels-1:0]       in_ready,
    input  logic [channels*width-1:0] in_data,
`ifdef ARB_MUXNV_LOCK_EN
    input  logic [channels-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel
);

    logic                out_valid_q, out_valid_d;
    logic [width-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]    ptr_q,       ptr_d;
    logic                load_en_s;
    logic [channels-1:0] grant_oh_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic                grant_any_s;
    logic [width-1:0]    win_data_s;
    logic [SEL_W-1:0]    next_ptr_s;
`ifdef ARB_MUXNV_LOCK_EN
    logic                locked_q,   locked_d;
    logic                out_last_q, out_last_d;
`endif

    rr_arbiter #(
        .channels    (channels)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (ptr_q),
`ifdef ARB_MUXNV_LOCK_EN
        .lock_i      (locked_q),
        .owner_i     (ptr_q),
`endif
        .grant_oh_o  (grant_oh_s),
        .grant_idx_o (grant_idx_s),
        .grant_any_o (grant_any_s)
    );

    // Output stage can take a new beat when empty or draining this cycle.
    // in_ready is held low during reset because the load would be discarded.
    always_comb begin
        load_en_s  = !out_valid_q || out_ready;
        in_ready   = (load_en_s && !reset) ? grant_oh_s : {channels{1'b0}};
        win_data_s = in_data[int'(grant_idx_s)*width +: width];
        next_ptr_s = (grant_idx_s == SEL_W'(channels-1)) ? {SEL_W{1'b0}}
                                                         : (grant_idx_s + SEL_W'(1));
    end

    // Next-state for the output register, pointer and lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef ARB_MUXNV_LOCK_EN
        locked_d    = locked_q;
        out_last_d  = out_last_q;
`endif
        if (load_en_s) begin
            if (grant_any_s) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data_s;
                out_sel_d   = grant_idx_s;
`ifdef ARB_MUXNV_LOCK_EN
                out_last_d  = in_last[grant_idx_s];
                if (!in_last[grant_idx_s]) begin
                    // Mid-packet: park the pointer on the owner.
                    locked_d = 1'b1;
                    ptr_d    = grant_idx_s;
                end else begin
                    locked_d = 1'b0;
                    ptr_d    = next_ptr_s;
                end
`else
                ptr_d       = next_ptr_s;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {width{1'b0}};
            out_sel_q   <= {SEL_W{1'b0}};
            ptr_q       <= {SEL_W{1'b0}};
`ifdef ARB_MUXNV_LOCK_EN
            locked_q    <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef ARB_MUXNV_LOCK_EN
            locked_q    <= locked_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef ARB_MUXNV_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_arb_muxnv.sv
module tb_arb_muxnv;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
`ifdef ARB_MUXNV_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
`ifdef ARB_MUXNV_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    arb_muxnv #(.width(W), .channels(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef ARB_MUXNV_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what the output register should hold, plus the
    // pending (not yet accepted) request of each producer.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;
    bit           m_locked;
    bit           m_last;
    bit           p_valid [N];
    logic [W-1:0] p_data  [N];
    bit           p_last  [N];
    bit           refill;

    function automatic int model_grant();
        if (m_locked) return p_valid[m_ptr] ? m_ptr : -1;
        for (int k = 0; k < N; k++) begin
            if (p_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]          = p_valid[i];
            in_data[i*W +: W]    = p_data[i];
`ifdef ARB_MUXNV_LOCK_EN
            in_last[i]           = p_last[i];
`endif
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_locked = 1'b0; m_last = 1'b0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, pass the rising edge.
    task automatic step();
        int           g;
        bit           load;
        logic [63:0]  exp_ready;
        drive();
        @(negedge clock);
        g         = model_grant();
        load      = !m_valid || out_ready;
        exp_ready = (reset || !load || g < 0) ? 64'd0 : (64'd1 << g);
        check("in_ready",  {60'd0, in_ready}, exp_ready);
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check("out_data",  {32'd0, out_data}, {32'd0, m_data});
        check("out_sel",   {62'd0, out_sel}, 64'(m_sel));
`ifdef ARB_MUXNV_LOCK_EN
        check("out_last",  {63'd0, out_last}, {63'd0, m_last});
`endif
        if (reset) begin
            model_reset();
        end else if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = p_data[g];
                m_sel   = g;
                m_last  = LOCK ? p_last[g] : 1'b0;
                if (LOCK && !p_last[g]) begin
                    m_locked = 1'b1;
                    m_ptr    = g;
                end else begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % N;
                end
                if (!refill) p_valid[g] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_pattern(input bit v0, input bit v1, input bit v2, input bit v3);
        p_valid[0] = v0; p_valid[1] = v1; p_valid[2] = v2; p_valid[3] = v3;
        for (int i = 0; i < N; i++) begin
            p_data[i] = 32'hA0 + 32'(i);
            p_last[i] = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        refill    = 1'b0;
        model_reset();
        set_pattern(1'b1, 1'b1, 1'b1, 1'b1);
        drive();
        @(posedge clock);
        #1;

        // Reset with all channels requesting.
        step();
        step();
        reset = 1'b0;

        // Round robin with every channel continuously valid.
        refill = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_sel",  {62'd0, out_sel}, 64'(k % 4));
            check("rr_data", {32'd0, out_data}, 64'(32'hA0 + (k % 4)));
        end
        refill = 1'b0;

        // Skip and wrap: ch2 then only ch0/ch1 pending.
        do_reset();
        set_pattern(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("skip_sel2", {62'd0, out_sel}, 64'd2);
        p_valid[0] = 1'b1; p_valid[1] = 1'b1;
        step();
        check("wrap_sel0", {62'd0, out_sel}, 64'd0);
        step();
        check("wrap_sel1", {62'd0, out_sel}, 64'd1);
        step();
        check("idle_valid", {63'd0, out_valid}, 64'd0);
        check("idle_sel",   {62'd0, out_sel}, 64'd1);

        // Back-pressure: hold ch3 beat while ch0/ch1 wait.
        p_valid[3] = 1'b1;
        step();
        check("bp_load", {62'd0, out_sel}, 64'd3);
        out_ready  = 1'b0;
        p_valid[0] = 1'b1; p_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_sel",  {62'd0, out_sel}, 64'd3);
            check("bp_hold_data", {32'd0, out_data}, 64'h0A3);
        end
        out_ready = 1'b1;
        step();
        check("bp_refill_sel",   {62'd0, out_sel}, 64'd0);
        check("bp_refill_valid", {63'd0, out_valid}, 64'd1);
        step();
        check("bp_next_sel", {62'd0, out_sel}, 64'd1);
        step();

        // Drain to empty from a single ch1 beat.
        do_reset();
        set_pattern(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("drain_sel", {62'd0, out_sel}, 64'd1);
        step();
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        check("drain_data",  {32'd0, out_data}, 64'h0A1);

`ifdef ARB_MUXNV_LOCK_EN
        // Packet lock on ch2 while ch0/ch1 keep requesting.
        do_reset();
        set_pattern(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_pattern(1'b1, 1'b1, 1'b1, 1'b0);
        p_last[2] = 1'b0;
        step();
        check("lock_sel_a", {62'd0, out_sel}, 64'd2);
        check("lock_last_a", {63'd0, out_last}, 64'd0);
        p_valid[2] = 1'b1; p_last[2] = 1'b0;
        step();
        check("lock_sel_b", {62'd0, out_sel}, 64'd2);
        p_valid[2] = 1'b1; p_last[2] = 1'b1;
        step();
        check("lock_sel_c", {62'd0, out_sel}, 64'd2);
        check("lock_last_c", {63'd0, out_last}, 64'd1);
        step();
        check("lock_resume0", {62'd0, out_sel}, 64'd0);
        step();
        check("lock_resume1", {62'd0, out_sel}, 64'd1);
`endif

        // Randomized traffic against the model.
        do_reset();
        set_pattern(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_valid[i] && ($urandom_range(0, 1) == 0)) begin
                    p_valid[i] = 1'b1;
                    p_data[i]  = $urandom;
                    p_last[i]  = ($urandom_range(0, 2) != 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
